// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word read at a time over req/gnt + rvalid and
// buffers returned {pc, instr} pairs in a small FIFO presented to decode with valid/ready.
module instr_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_go,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_read_enable_cpu,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_fetch_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_instr,
  input  logic            i_id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_next_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];

  logic            w_inflight;
  logic [CW:0]     w_occupancy;
  logic            w_space;
  logic            w_issue;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_unused;

  // Low pc bits never reach memory; NOP_INSTR is reserved for checking only.
  assign w_unused = ^{NOP_INSTR, i_pc[1:0]};

  assign w_inflight  = (r_state == StWait) || (r_state == StDrop);
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, w_inflight};
  assign w_space     = w_occupancy < (CW + 1)'(DEPTH);
  assign w_issue     = (r_state == StIdle) && i_go && i_read_enable_cpu && !i_flush && w_space;
  assign w_pop       = o_if_valid && i_id_ready && i_go && !i_flush;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_issue) w_state_next = StReq;
      end
      StReq: begin
        // A grant that coincides with a flush still leaves a response to swallow.
        if (i_flush) begin
          w_state_next = i_imem_gnt ? StDrop : StIdle;
        end else if (i_go && i_imem_gnt) begin
          w_state_next = StWait;
          w_grant      = 1'b1;
        end
      end
      StWait: begin
        if (i_flush) begin
          w_state_next = i_imem_rvalid ? StIdle : StDrop;
        end else if (i_go && i_imem_rvalid) begin
          w_state_next = StIdle;
          w_push       = 1'b1;
        end
      end
      StDrop: begin
        if (i_go && i_imem_rvalid) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_req_pc  <= '0;
      r_next_pc <= '0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) r_req_pc <= {i_pc[XLEN-1:2], 2'b00};
      if (w_grant) r_next_pc <= r_req_pc + XLEN'(4);
      if (i_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= i_imem_rdata;
    end
  end

  assign o_imem_req    = (r_state == StReq);
  assign o_imem_addr   = o_imem_req ? r_req_pc : '0;
  assign o_next_pc     = r_next_pc;
  assign o_fetch_stall = !((r_state == StIdle) && w_space) || i_reset;
  assign o_if_valid    = (r_count != '0);
  assign o_if_pc       = o_if_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign o_if_instr    = o_if_valid ? r_instr_mem[r_rd_ptr] : '0;

  // Address must not move while a request is waiting for its grant.
  a_req_hold : assert property (@(posedge i_clk) disable iff (i_reset)
    (o_imem_req && !i_imem_gnt && !i_flush) |=> (o_imem_req && $stable(o_imem_addr)));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Takes the current pc and read_enable_cpu, issues word reads to instruction memory over a req/gnt + rvalid handshake, and buffers returned instructions in a small FIFO.
- Presents {pc, instr} to decode with valid/ready.
- Feeds the incremented PC back as next_pc, which goes to the PC register's prev_pc input. Drives fetch_stall for the stall vector.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 2, response FIFO entries (power of two, >=2).
- NOP_INSTR, 32'h00000013, reserved encoding (addi x0,x0,0) for bench checks; never emitted by the block.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- go  in  1  global run enable; 0 freezes all state (flush and reset still act).
- pc  in  XLEN  fetch address from PC register.
- read_enable_cpu  in  1  pc is valid for fetch.
- flush  in  1  branch taken; discard all buffered/in-flight instructions.
- next_pc  out  XLEN  pc+4 of last granted request; to PC register prev_pc.
- fetch_stall  out  1  1 when no request can be issued this cycle.
- imem_req  out  1  memory read request.
- imem_addr  out  XLEN  word address; bits [1:0] forced to 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  instruction word.
- if_valid  out  1  FIFO head valid.
- if_pc  out  XLEN  PC of head entry.
- if_instr  out  XLEN  instruction of head entry.
- id_ready  in  1  decode accepts head.

Behaviour:
- Reset values: state=IDLE, FIFO empty (count=0), next_pc=0, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, fetch_stall=1. Reset mid-transaction abandons any outstanding response. A late rvalid arriving after reset is ignored until a new grant.
- FSM states:
  - IDLE: issue only if go && read_enable_cpu && !flush && (count + inflight) < DEPTH. Otherwise stay.
  - REQ: imem_req=1 with imem_addr={pc[XLEN-1:2],2'b00}, captured into req_pc. Hold req/addr stable until imem_gnt. On gnt go to WAIT, next_pc <= req_pc+4 (mod 2^XLEN; 32'hFFFFFFFC wraps to 0).
  - WAIT: on imem_rvalid, push {req_pc, imem_rdata}, then go to IDLE. Same-cycle re-issue is not allowed (one bubble between requests).
  - DROP: entered from WAIT on flush. Next rvalid is discarded (no push), then IDLE.
- At most one outstanding request (inflight = state is WAIT or DROP).
- Flush in IDLE: FIFO cleared, no request issued that cycle.
- Flush in REQ: if gnt arrives the same cycle, go to DROP; otherwise deassert req and go to IDLE. next_pc is not updated on a flushed request.
- Flush in WAIT: FIFO cleared, go to DROP. If rvalid arrives the same cycle, it is dropped and the FSM goes straight to IDLE.
- Flush has priority over push and pop in the same cycle. Reset has priority over flush.
- FIFO behaviour:
  - if_valid = (count != 0); head registered.
  - Pop when if_valid && id_ready.
  - Push and pop in the same cycle with count=DEPTH cannot occur, because issue is gated on space.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- fetch_stall = !(state==IDLE && (count+inflight)<DEPTH) || reset.
- go=0: no state transitions, no push/pop. imem_req is held if already in REQ, since an address must not change while req is high.
- Latency: pc sampled in IDLE at cycle N; req at N+1; with gnt at N+1 and rvalid at N+2, if_valid rises at N+3.
- Every instruction emitted carries exactly the PC it was fetched from; order is preserved.

Test Plan:
- Reset then pc=0, read_enable_cpu=1, gnt immediate, rvalid next cycle with rdata=32'h00500093, id_ready=1 → imem_addr=0, next_pc=4, if_valid=1 with if_pc=0, if_instr=32'h00500093, 3 cycles after pc sampled.
- Back-to-back fetches pc=0,4,8 with id_ready=0 → two entries buffered (pcs 0 and 4), fetch_stall=1, no third req. Raising id_ready pops 0 then 4 and fetch resumes at 8.
- gnt delayed 3 cycles with pc=32'h100 → imem_req and imem_addr=32'h100 held stable for all 3 cycles. next_pc=32'h104 only after gnt.
- flush while in WAIT with pc=32'h20 outstanding, rvalid 2 cycles later → response dropped, FIFO empty, if_valid stays 0. Next fetch at pc=32'h80 emits if_pc=32'h80.
- pc=32'hFFFFFFFC granted → next_pc=0. Misaligned pc=32'h13 → imem_addr=32'h10.
- Reset asserted in WAIT, then rvalid arrives → all outputs at reset values, no entry pushed.
